// File: rtl/running_max_2bit_if.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------+
// | running_max_2bit_if : sample-in / window-result-out bundle            |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
interface running_max_2bit_if;
  logic       in_valid;
  logic [1:0] in_data;
  logic       in_ready;
  logic       new_max;
  logic [1:0] win_max;
  logic [3:0] win_cnt;
  logic       win_valid;
  logic       out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, new_max, win_max, win_cnt, win_valid
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, new_max, win_max, win_cnt, win_valid
  );
endinterface
`default_nettype wire

// File: rtl/running_max_2bit.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------+
// | running_max_2bit : windowed running maximum of 2-bit unsigned samples |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module running_max_2bit #(
  parameter int WINDOW = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  running_max_2bit_if.slave  bus
);

  localparam logic [3:0] C_WINDOW = 4'(WINDOW);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_max, w_max_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       r_new_max, w_new_max_nxt;
  logic       w_accept;

  assign w_accept = bus.in_valid && (r_state != REPORT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_max     <= 2'd0;
      r_cnt     <= 4'd0;
      r_new_max <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_max     <= w_max_nxt;
      r_cnt     <= w_cnt_nxt;
      r_new_max <= w_new_max_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_max_nxt     = r_max;
    w_cnt_nxt     = r_cnt;
    w_new_max_nxt = 1'b0;
    if (clear) begin
      // Abort wins over any sample or consumer handshake on the same edge.
      w_state_nxt = IDLE;
      w_max_nxt   = 2'd0;
      w_cnt_nxt   = 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            w_max_nxt     = bus.in_data;
            w_cnt_nxt     = 4'd1;
            w_new_max_nxt = 1'b1;
            w_state_nxt   = TRACK;
          end
        end
        TRACK: begin
          if (w_accept) begin
            w_cnt_nxt = r_cnt + 4'd1;
            if (bus.in_data > r_max) begin
              w_max_nxt     = bus.in_data;
              w_new_max_nxt = 1'b1;
            end
            if (w_cnt_nxt == C_WINDOW) begin
              w_state_nxt = REPORT;
            end
          end
        end
        REPORT: begin
          if (bus.out_ready) begin
            w_state_nxt = IDLE;
            w_max_nxt   = 2'd0;
            w_cnt_nxt   = 4'd0;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_max_nxt   = 2'd0;
          w_cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_state != REPORT);
  assign bus.win_valid = (r_state == REPORT);
  assign bus.new_max   = r_new_max;
  assign bus.win_max   = r_max;
  assign bus.win_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_running_max_2bit.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------+
// | tb_running_max_2bit : directed + random check against a sample model  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_running_max_2bit;

  localparam int C_WINDOW = 8;

  logic clk;
  logic rst_n;
  logic clear;
  running_max_2bit_if bus();

  running_max_2bit #(.WINDOW(C_WINDOW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;
  bit chk_en;

  task automatic check(input string name, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act != exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: remembers every sample accepted into the current window.
  int samp [16];
  int m_n;
  bit m_report;
  bit m_new;

  function automatic int hist_max();
    int mx;
    mx = 0;
    for (int i = 0; i < m_n; i++) if (samp[i] > mx) mx = samp[i];
    return mx;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n      <= 0;
      m_report <= 1'b0;
      m_new    <= 1'b0;
    end else begin
      m_new <= 1'b0;
      if (clear) begin
        m_n      <= 0;
        m_report <= 1'b0;
      end else if (m_report) begin
        if (bus.out_ready) begin
          m_n      <= 0;
          m_report <= 1'b0;
        end
      end else if (bus.in_valid) begin
        samp[m_n] <= int'(bus.in_data);
        m_n       <= m_n + 1;
        m_new     <= (m_n == 0) || (int'(bus.in_data) > hist_max());
        m_report  <= (m_n + 1 == C_WINDOW);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready",  int'(bus.in_ready),  int'(!m_report));
      check("win_valid", int'(bus.win_valid), int'(m_report));
      check("new_max",   int'(bus.new_max),   int'(m_new));
      check("win_cnt",   int'(bus.win_cnt),   m_n);
      check("win_max",   int'(bus.win_max),   hist_max());
    end
  end

  task automatic drive(input bit v, input logic [1:0] d, input bit orr, input bit clr);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = orr;
    clear         = clr;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [1:0] seq_a [8];
  bit         nm_a  [8];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    chk_en = 1'b0;
    seq_a = '{2'd1, 2'd0, 2'd2, 2'd2, 2'd3, 2'd1, 2'd0, 2'd3};
    nm_a  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    bus.in_valid = 1'b0; bus.in_data = 2'd0; bus.out_ready = 1'b0; clear = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", int'(bus.in_ready), 1);
    check("rst_cnt",   int'(bus.win_cnt), 0);
    check("rst_valid", int'(bus.win_valid), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Back-to-back window with known new_max pattern.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, seq_a[i], 1'b0, 1'b0);
      after_edge();
      check("seq_new_max", int'(bus.new_max), int'(nm_a[i]));
    end
    check("seq_valid", int'(bus.win_valid), 1);
    check("seq_max",   int'(bus.win_max), 3);
    check("seq_cnt",   int'(bus.win_cnt), 8);

    // Result held while the consumer stalls.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
      after_edge();
      check("hold_ready", int'(bus.in_ready), 0);
      check("hold_cnt",   int'(bus.win_cnt), 8);
      check("hold_max",   int'(bus.win_max), 3);
    end
    drive(1'b1, 2'd2, 1'b1, 1'b0);
    after_edge();
    check("drain_cnt",   int'(bus.win_cnt), 0);
    check("drain_valid", int'(bus.win_valid), 0);
    check("drain_max",   int'(bus.win_max), 0);

    // Constant samples: only the first raises the maximum.
    for (int i = 0; i < C_WINDOW; i++) begin
      drive(1'b1, 2'd2, 1'b0, 1'b0);
      after_edge();
      check("const_new_max", int'(bus.new_max), (i == 0) ? 1 : 0);
    end
    check("const_max", int'(bus.win_max), 2);
    drive(1'b0, 2'd0, 1'b1, 1'b0);

    // Clear beats a simultaneous sample.
    for (int i = 0; i < 3; i++) drive(1'b1, 2'(i), 1'b0, 1'b0);
    drive(1'b1, 2'd3, 1'b0, 1'b1);
    after_edge();
    check("clr_cnt", int'(bus.win_cnt), 0);
    check("clr_max", int'(bus.win_max), 0);
    drive(1'b0, 2'd0, 1'b0, 1'b0);

    // Asynchronous reset mid-window.
    for (int i = 0; i < 5; i++) drive(1'b1, 2'd1, 1'b0, 1'b0);
    after_edge();
    bus.in_valid = 1'b0;
    check("pre_rst_cnt", int'(bus.win_cnt), 5);
    #2 rst_n = 1'b0;
    #1;
    check("arst_cnt",     int'(bus.win_cnt), 0);
    check("arst_max",     int'(bus.win_max), 0);
    check("arst_new_max", int'(bus.new_max), 0);
    check("arst_ready",   int'(bus.in_ready), 1);
    check("arst_valid",   int'(bus.win_valid), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    drive(1'b1, 2'd0, 1'b0, 1'b0);
    after_edge();
    check("post_rst_new_max", int'(bus.new_max), 1);
    check("post_rst_cnt",     int'(bus.win_cnt), 1);

    // Gapped input: only valid cycles count.
    for (int i = 0; i < 2 * C_WINDOW - 1; i++)
      drive(i[0] == 1'b0, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
    after_edge();
    check("gap_valid", int'(bus.win_valid), 1);
    check("gap_cnt",   int'(bus.win_cnt), C_WINDOW);
    drive(1'b0, 2'd0, 1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 2000; i++)
      drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 40) == 0));
    drive(1'b0, 2'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/running_max_2bit.md
RUNNING_MAX_2BIT -- requirements
Module: running_max_2bit

Interface
REQ-001 SHALL have parameter WINDOW, default 8, number of accepted samples per reporting window; legal range 2..15.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert and active-low.
REQ-004 SHALL have port clear  input  1  synchronous abort of the current window.
REQ-005 SHALL have port in_valid  input  1  in_data holds a sample.
REQ-006 SHALL have port in_data  input  2  unsigned sample.
REQ-007 SHALL have port in_ready  output  1  block can accept a sample.
REQ-008 SHALL have port new_max  output  1  one-cycle pulse: the previous accept raised the running maximum.
REQ-009 SHALL have port win_max  output  2  running/final maximum of the window, unsigned.
REQ-010 SHALL have port win_cnt  output  4  samples accepted in the current window.
REQ-011 SHALL have port win_valid  output  1  window complete, result held on win_max.
REQ-012 SHALL have port out_ready  input  1  consumer takes the window result.

Function
REQ-013 SHALL implement FSM with states IDLE (no sample yet), TRACK (window in progress), REPORT (result held).
REQ-014 Accept SHALL occur exactly on a rising edge with in_valid=1 and in_ready=1; in_ready SHALL be 1 in IDLE and TRACK, 0 in REPORT (decoded from state).
REQ-015 IDLE accept: win_max <= in_data unconditionally, win_cnt <= 1, new_max <= 1, go TRACK.
REQ-016 TRACK accept: win_max <= in_data and new_max <= 1 only if in_data > win_max (strict unsigned compare); equal or smaller leaves win_max unchanged and new_max <= 0; win_cnt increments by 1.
REQ-017 new_max SHALL be 0 on every cycle not immediately following a qualifying accept.
REQ-018 When an accept makes win_cnt equal WINDOW, next state SHALL be REPORT and win_valid SHALL be 1 from the following cycle (1-cycle latency).
REQ-019 In REPORT: win_max, win_cnt held stable; in_valid ignored; win_valid stays 1 until out_ready=1.
REQ-020 REPORT with out_ready=1 on an edge: go IDLE, win_valid <= 0, win_cnt <= 0, win_max <= 0; no sample accepted that cycle.
REQ-021 out_ready SHALL be ignored outside REPORT.
REQ-022 clear=1 on an edge SHALL take priority over all other events in any state: go IDLE, win_cnt <= 0, win_max <= 0, win_valid <= 0, new_max <= 0; a simultaneous in_valid sample is dropped.
REQ-023 win_cnt SHALL never exceed WINDOW and never wrap.
REQ-024 Max value 3 in TRACK: further samples SHALL still be counted; no new_max since none can exceed 3.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, win_max=0, win_cnt=0, win_valid=0, new_max=0, in_ready=1, independent of clk.
REQ-026 Reset asserted mid-window or in REPORT SHALL discard the window; first accept after rst_n rises follows REQ-015.

Verification
REQ-027 Reset then WINDOW=8, samples 1,0,2,2,3,1,0,3 back-to-back -> new_max pulses after samples 1,3,5 only; win_valid=1 cycle after 8th accept with win_max=3, win_cnt=8.
REQ-028 Window complete, out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, win_max/win_cnt stable, no accepts; then out_ready=1 -> IDLE, win_cnt=0, win_valid=0.
REQ-029 Samples 2,2,2,... -> single new_max after first sample; win_max=2 at report.
REQ-030 After 3 samples (max=2) assert clear with in_valid=1, in_data=3 -> win_cnt=0, win_max=0, sample 3 not counted.
REQ-031 Assert rst_n=0 between clock edges during TRACK (win_cnt=5) -> outputs reach reset values before next edge.
REQ-032 Gaps: in_valid toggled 1/0 every cycle -> only valid cycles counted; report after exactly WINDOW accepts.
